// File: rtl/elastic_pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipeline_pkg
//  Brief    : Shared types for the elastic pipeline (per-stage state encoding
//             and an occupancy helper).
//  Revision : 1.0 - initial release
// ============================================================================
package elastic_pipeline_pkg;

    // Per-stage occupancy state: no entry, main register only, main + skid.
    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_BUSY  = 2'd1,
        STG_FULL  = 2'd2
    } stage_state_t;

    // Number of entries a stage holds in a given state.
    function automatic logic [1:0] stage_count(input stage_state_t s);
        case (s)
            STG_BUSY: stage_count = 2'd1;
            STG_FULL: stage_count = 2'd2;
            default:  stage_count = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_pipeline_if.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipeline_if
//  Brief    : Valid/ready/data stream bundle. The master drives valid and
//             data, the slave drives ready.
//  Revision : 1.0 - initial release
// ============================================================================
interface elastic_pipeline_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/elastic_pipeline_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : skid_stage
//  Brief    : One elastic stage: a main register feeding downstream plus a
//             skid register that absorbs the beat arriving in the same cycle
//             the downstream stalls. Upstream ready is a pure flop output.
//  Revision : 1.0 - initial release
// ============================================================================
module skid_stage
    import elastic_pipeline_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             flush,
    input  wire logic             in_valid_i,
    output logic                  in_ready_o,
    input  wire logic [WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  wire logic             out_ready_i,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [1:0]            count_o
);

    stage_state_t     state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             w_accept;
    logic             w_drain;

    assign w_accept = in_valid_i & ready_q;
    assign w_drain  = (state_q != STG_EMPTY) & out_ready_i;

    // Next-state and data steering for the EMPTY/BUSY/FULL stage machine.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            STG_EMPTY: begin
                if (w_accept) begin
                    state_d = STG_BUSY;
                    main_d  = in_data_i;
                end
            end
            STG_BUSY: begin
                if (w_accept && !w_drain) begin
                    state_d = STG_FULL;
                    skid_d  = in_data_i;
                end else if (w_accept && w_drain) begin
                    main_d  = in_data_i;
                end else if (w_drain) begin
                    state_d = STG_EMPTY;
                end
            end
            STG_FULL: begin
                // ready_q is low here, so only a drain can happen.
                if (w_drain) begin
                    state_d = STG_BUSY;
                    main_d  = skid_q;
                    skid_d  = RESET_VALUE;
                end
            end
            default: state_d = STG_EMPTY;
        endcase
    end

    // State registers; reset and flush both return the stage to EMPTY.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= STG_EMPTY;
            ready_q <= 1'b1;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != STG_FULL);
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != STG_EMPTY);
    assign out_data_o  = main_q;
    assign count_o     = stage_count(state_q);

endmodule
`default_nettype wire

// File: rtl/elastic_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipeline
//  Brief    : Chain of STAGES skid stages with valid/ready flow control,
//             synchronous flush and an occupancy count of held beats.
//  Revision : 1.0 - initial release
// ============================================================================
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire logic                           flush,
    elastic_pipeline_if.slave                   in_if,
    elastic_pipeline_if.master                  out_if,
    output logic [$clog2(2*STAGES+1)-1:0]       occupancy
);

    localparam int OCC_W = $clog2(2*STAGES+1);

    // Index i is the link feeding stage i; index STAGES is the chain output.
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [WIDTH-1:0] w_data  [STAGES+1];
    logic [1:0]       w_count [STAGES];
    logic [OCC_W-1:0] w_occ;

    assign w_valid[0]      = in_if.valid;
    assign w_data[0]       = in_if.data;
    assign in_if.ready     = w_ready[0];
    assign out_if.valid    = w_valid[STAGES];
    assign out_if.data     = w_data[STAGES];
    assign w_ready[STAGES] = out_if.ready;

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            skid_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk         (clk),
                .reset       (reset),
                .flush       (flush),
                .in_valid_i  (w_valid[g]),
                .in_ready_o  (w_ready[g]),
                .in_data_i   (w_data[g]),
                .out_valid_o (w_valid[g+1]),
                .out_ready_i (w_ready[g+1]),
                .out_data_o  (w_data[g+1]),
                .count_o     (w_count[g])
            );
        end
    endgenerate

    // Total beats held across all stages.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(w_count[i]);
        end
    end

    assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipeline.sv
`timescale 1ns/1ps
module tb_elastic_pipeline;

    localparam logic [31:0] RV2 = 32'hCAFE_F00D;
    localparam logic [7:0]  RV1 = 8'h5A;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] occ2;
    logic [1:0] occ1;
    int         errors = 0;
    int         checks = 0;

    elastic_pipeline_if #(.WIDTH(32)) a_in  ();
    elastic_pipeline_if #(.WIDTH(32)) a_out ();
    elastic_pipeline_if #(.WIDTH(8))  b_in  ();
    elastic_pipeline_if #(.WIDTH(8))  b_out ();

    elastic_pipeline #(.WIDTH(32), .STAGES(2), .RESET_VALUE(RV2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_if(a_in), .out_if(a_out), .occupancy(occ2)
    );

    elastic_pipeline #(.WIDTH(8), .STAGES(1), .RESET_VALUE(RV1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_if(b_in), .out_if(b_out), .occupancy(occ1)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%0b required=0", a_out.valid); end
        checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready actual=%0b required=1", a_in.ready); end
        checks++; if (occ2 !== 3'd0) begin errors++; $display("FAIL reset_occupancy actual=%0d required=0", occ2); end
        checks++; if (a_out.data !== RV2) begin errors++; $display("FAIL reset_out_data actual=%h required=%h", a_out.data, RV2); end
        checks++; if (b_out.valid !== 1'b0 || b_in.ready !== 1'b1 || occ1 !== 2'd0) begin
            errors++; $display("FAIL reset_s1_ctrl actual v=%0b r=%0b occ=%0d required v=0 r=1 occ=0", b_out.valid, b_in.ready, occ1);
        end
        checks++; if (b_out.data !== RV1) begin errors++; $display("FAIL reset_s1_data actual=%h required=%h", b_out.data, RV1); end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        int first = -1;
        reset = 1'b0;
        a_out.ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            a_in.valid = (sent < 16);
            a_in.data  = 32'(sent + 1);
            if (a_in.valid) begin
                checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cycle=%0d actual=%0b required=1", c, a_in.ready); end
            end
            if (a_out.valid === 1'b1) begin
                if (first < 0) first = c;
                checks++; if (a_out.data !== 32'(got + 1)) begin errors++; $display("FAIL stream_data actual=%h required=%h", a_out.data, 32'(got + 1)); end
                checks++; if (c != first + got) begin errors++; $display("FAIL stream_rate beat=%0d actual_cycle=%0d required_cycle=%0d", got, c, first + got); end
                got++;
            end
            if (a_in.valid && a_in.ready) sent++;
            step();
        end
        a_in.valid = 1'b0;
        checks++; if (first != 2) begin errors++; $display("FAIL stream_latency actual=%0d required=2", first); end
        checks++; if (got != 16) begin errors++; $display("FAIL stream_count actual=%0d required=16", got); end
    endtask

    task automatic test_fill();
        logic [31:0] q[$];
        int got = 0;
        a_out.ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            a_in.valid = 1'b1;
            a_in.data  = 32'h100 + 32'(c);
            if (a_in.ready === 1'b1) q.push_back(a_in.data);
            step();
        end
        a_in.valid = 1'b0;
        checks++; if (q.size() != 4) begin errors++; $display("FAIL fill_accepted actual=%0d required=4", q.size()); end
        checks++; if (occ2 !== 3'd4) begin errors++; $display("FAIL fill_occupancy actual=%0d required=4", occ2); end
        checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready actual=%0b required=0", a_in.ready); end
        a_out.ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_out.valid === 1'b1) begin
                checks++;
                if (got >= q.size()) begin errors++; $display("FAIL fill_extra_beat actual=%h required=none", a_out.data); end
                else if (a_out.data !== q[got]) begin errors++; $display("FAIL fill_order actual=%h required=%h", a_out.data, q[got]); end
                got++;
            end
            step();
        end
        checks++; if (got != 4) begin errors++; $display("FAIL fill_drained actual=%0d required=4", got); end
        checks++; if (occ2 !== 3'd0) begin errors++; $display("FAIL fill_empty_occ actual=%0d required=0", occ2); end
    endtask

    task automatic test_random();
        logic [31:0] mq[$];
        int          delivered = 0;
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        while (delivered < 10000 && cyc < 60000) begin
            a_in.valid  = 1'($urandom % 2);
            a_in.data   = $urandom;
            a_out.ready = 1'($urandom % 2);
            checks++; if (int'(occ2) != mq.size()) begin errors++; $display("FAIL rand_occupancy cycle=%0d actual=%0d required=%0d", cyc, occ2, mq.size()); end
            if (prev_stall) begin
                checks++; if (a_out.valid !== 1'b1 || a_out.data !== prev_data) begin
                    errors++; $display("FAIL rand_stable cycle=%0d actual v=%0b d=%h required v=1 d=%h", cyc, a_out.valid, a_out.data, prev_data);
                end
            end
            if (a_out.valid === 1'b1) begin
                checks++;
                if (mq.size() == 0) begin errors++; $display("FAIL rand_spurious cycle=%0d actual=%h required=no beat", cyc, a_out.data); end
                else if (a_out.data !== mq[0]) begin errors++; $display("FAIL rand_data cycle=%0d actual=%h required=%h", cyc, a_out.data, mq[0]); end
            end
            if (a_out.valid === 1'b1 && a_out.ready && mq.size() > 0) begin
                void'(mq.pop_front());
                delivered++;
            end
            if (a_in.valid && a_in.ready === 1'b1) mq.push_back(a_in.data);
            prev_stall = (a_out.valid === 1'b1) && !a_out.ready;
            prev_data  = a_out.data;
            step();
            cyc++;
        end
        a_in.valid = 1'b0;
        checks++; if (delivered < 10000) begin errors++; $display("FAIL rand_timeout actual=%0d required=10000", delivered); end
    endtask

    task automatic test_flush();
        int seen = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_out.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_in.valid = 1'b1;
            a_in.data  = 32'h200 + 32'(k);
            step();
        end
        checks++; if (occ2 !== 3'd3) begin errors++; $display("FAIL flush_pre_occ actual=%0d required=3", occ2); end
        flush = 1'b1;
        a_in.valid = 1'b1;
        a_in.data  = 32'h777;
        step();
        flush = 1'b0;
        a_in.valid = 1'b0;
        checks++; if (occ2 !== 3'd0) begin errors++; $display("FAIL flush_occ actual=%0d required=0", occ2); end
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid actual=%0b required=0", a_out.valid); end
        checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready actual=%0b required=1", a_in.ready); end
        checks++; if (a_out.data !== RV2) begin errors++; $display("FAIL flush_out_data actual=%h required=%h", a_out.data, RV2); end
        a_out.ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (a_out.valid === 1'b1) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_leak actual=%0d required=0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        a_out.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_in.valid = 1'b1;
            a_in.data  = 32'h300 + 32'(k);
            step();
        end
        reset = 1'b1;
        a_in.valid = 1'b1;
        a_in.data  = 32'h399;
        step();
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid actual=%0b required=0", a_out.valid); end
        checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready actual=%0b required=1", a_in.ready); end
        checks++; if (occ2 !== 3'd0) begin errors++; $display("FAIL midreset_occ actual=%0d required=0", occ2); end
        checks++; if (a_out.data !== RV2) begin errors++; $display("FAIL midreset_out_data actual=%h required=%h", a_out.data, RV2); end
        reset = 1'b0;
        a_in.valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (a_out.valid === 1'b1) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_leak actual=%0d required=0", seen); end
    endtask

    task automatic test_fill_s1();
        logic [7:0] q[$];
        int got = 0;
        b_out.ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            b_in.valid = 1'b1;
            b_in.data  = 8'h40 + 8'(c);
            if (b_in.ready === 1'b1) q.push_back(b_in.data);
            step();
        end
        b_in.valid = 1'b0;
        checks++; if (q.size() != 2) begin errors++; $display("FAIL s1_accepted actual=%0d required=2", q.size()); end
        checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL s1_occupancy actual=%0d required=2", occ1); end
        checks++; if (b_in.ready !== 1'b0) begin errors++; $display("FAIL s1_in_ready actual=%0b required=0", b_in.ready); end
        b_out.ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (b_out.valid === 1'b1) begin
                checks++;
                if (got >= q.size()) begin errors++; $display("FAIL s1_extra_beat actual=%h required=none", b_out.data); end
                else if (b_out.data !== q[got]) begin errors++; $display("FAIL s1_order actual=%h required=%h", b_out.data, q[got]); end
                got++;
            end
            step();
        end
        checks++; if (got != 2) begin errors++; $display("FAIL s1_drained actual=%0d required=2", got); end
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        a_in.valid  = 1'b0;
        a_in.data   = '0;
        a_out.ready = 1'b0;
        b_in.valid  = 1'b0;
        b_in.data   = '0;
        b_out.ready = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_random();
        test_flush();
        test_reset_mid();
        test_fill_s1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
